// File: rtl/memref_rd_streamer.sv
// Address-range read sequencer for memref_rd: issues reads, buffers returned words in a
// first-word fall-through FIFO and replays them as a valid/ready stream.
module memref_rd_streamer #(
  parameter int WIDTH      = 32,
  parameter int SIZE       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tstart,
  input  logic [$clog2(SIZE)-1:0]  base,
  input  logic [$clog2(SIZE):0]    count,
  output logic                     rd_en,
  output logic [$clog2(SIZE)-1:0]  addr,
  input  logic                     dout_valid,
  input  logic [WIDTH-1:0]         dout,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int AW = $clog2(SIZE);
  localparam int CW = $clog2(SIZE) + 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int IW = $clog2(FIFO_DEPTH);
  localparam logic [OW-1:0] DEPTH_V = OW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [CW-1:0]     issued, issued_n;
  logic [AW-1:0]     ptr, ptr_n;
  logic [AW-1:0]     addr_n;
  logic              issue_n;
  logic [OW-1:0]     occ, occ_n;
  logic [OW-1:0]     infl, infl_n;
  logic [IW-1:0]     wr_ptr, rd_ptr;
  logic [WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic              pop, push, full, retire, err_ev;

  // Address space need not be a power of two, so wrap by compare.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(SIZE - 1)) ? '0 : a + AW'(1);
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(FIFO_DEPTH - 1)) ? '0 : i + IW'(1);
  endfunction

  always_comb begin
    pop    = (occ != '0) && out_ready;
    full   = (occ == DEPTH_V);
    // A return with nothing outstanding is a stray and never enters the FIFO.
    retire = dout_valid && (infl != '0);
    push   = retire && (!full || pop);
    err_ev = dout_valid && ((infl == '0) || (full && !pop));
    occ_n  = occ + OW'(push) - OW'(pop);
    infl_n = infl + OW'(rd_en) - OW'(retire);

    state_n  = state;
    cnt_n    = cnt;
    issued_n = issued;
    ptr_n    = ptr;
    case (state)
      ST_IDLE: begin
        if (tstart) begin
          cnt_n    = count;
          ptr_n    = base;
          issued_n = '0;
          state_n  = (count == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issued == cnt) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((occ == '0) && (infl == '0) && !rd_en) state_n = ST_DONE;
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase

    // Next-cycle issue decision: reserve a FIFO slot for every word still in flight.
    issue_n = (state_n == ST_ISSUE) && (issued_n < cnt_n) && ((occ_n + infl_n) < DEPTH_V);
    addr_n  = addr;
    if (issue_n) begin
      addr_n   = ptr_n;
      ptr_n    = next_addr(ptr_n);
      issued_n = issued_n + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      issued <= '0;
      ptr    <= '0;
      rd_en  <= 1'b0;
      addr   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      occ    <= '0;
      infl   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      issued <= issued_n;
      ptr    <= ptr_n;
      rd_en  <= issue_n;
      addr   <= addr_n;
      busy   <= (state_n != ST_IDLE);
      done   <= (state == ST_DONE);
      err    <= err | err_ev;
      occ    <= occ_n;
      infl   <= infl_n;
      if (push) wr_ptr <= next_idx(wr_ptr);
      if (pop)  rd_ptr <= next_idx(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= dout;
  end

  assign out_valid = (occ != '0);
  assign out_data  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_memref_rd_streamer.sv
// Randomized scoreboard bench for memref_rd_streamer with a small memref_rd model attached.
module tb_memref_rd_streamer;

  localparam int WIDTH = 32;
  localparam int SIZE  = 8;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tstart = 1'b0;
  logic [2:0]        base = '0;
  logic [3:0]        count = '0;
  logic              rd_en;
  logic [2:0]        addr;
  logic              dout_valid;
  logic [WIDTH-1:0]  dout;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_ready = 1'b1;
  logic              busy, done, err;

  logic              dv_q;
  logic [WIDTH-1:0]  rdata_q;
  logic              inj = 1'b0;
  logic [WIDTH-1:0]  mem [SIZE];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_rd  = 0;
  int n_done = 0;
  int rd_base = 0;
  int done_base = 0;
  int first_acc = -1;
  int last_acc  = -1;
  bit exp_err = 1'b0;
  longint exp_q [$];
  longint addr_q [$];

  memref_rd_streamer #(.WIDTH(WIDTH), .SIZE(SIZE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tstart(tstart), .base(base), .count(count),
    .rd_en(rd_en), .addr(addr), .dout_valid(dout_valid), .dout(dout),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // memref_rd model: one-cycle read latency
  always @(posedge clk or posedge rst) begin
    if (rst) dv_q <= 1'b0;
    else     dv_q <= rd_en;
  end
  always @(posedge clk) rdata_q <= mem[addr];
  assign dout_valid = dv_q | inj;
  assign dout       = inj ? 32'h0000_0BAD : rdata_q;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Monitor: pops the scoreboard whenever the stream or read port presents something.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("out_unexpected", longint'(out_data), -1);
        else                   chk("out_data", longint'(out_data), exp_q.pop_front());
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (rd_en) begin
        n_rd++;
        if (addr_q.size() == 0) chk("addr_unexpected", longint'(addr), -1);
        else                    chk("addr", longint'(addr), addr_q.pop_front());
      end
      if (done) n_done++;
    end
  end

  task automatic start(input int b, input int c);
    for (int i = 0; i < c; i++) begin
      exp_q.push_back(100 + (b + i) % SIZE);
      addr_q.push_back((b + i) % SIZE);
    end
    rd_base   = n_rd;
    done_base = n_done;
    first_acc = -1;
    last_acc  = -1;
    base   = 3'(b);
    count  = 4'(c);
    tstart = 1'b1;
    @(posedge clk); #1;
    tstart = 1'b0;
  endtask

  // mode 1: out_ready held high; mode 2: random backpressure
  task automatic wait_done(input int mode);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #1;
      out_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (n_done > done_base) seen = 1'b1;
    end
    out_ready = 1'b1;
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic finish_xfer(input int c, input bit ones);
    repeat (2) @(posedge clk);
    #1;
    chk("done_pulses", n_done - done_base, 1);
    chk("words_left", exp_q.size(), 0);
    chk("rd_en_count", n_rd - rd_base, c);
    chk("err", err, exp_err);
    chk("busy_after", busy, 0);
    if (ones && c > 0) chk("throughput", last_acc - first_acc, c - 1);
  endtask

  task automatic xfer(input int b, input int c, input int mode);
    start(b, c);
    wait_done(mode);
    finish_xfer(c, mode == 1);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_err = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < SIZE; i++) mem[i] = 32'(100 + i);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_addr", addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // full range, streaming
    start(0, 8);
    chk("busy_start", busy, 1);
    wait_done(1);
    finish_xfer(8, 1'b1);

    // wrap around the top of memory
    xfer(6, 4, 1);

    // empty transfer
    start(0, 0);
    chk("cnt0_done_early", done, 0);
    @(posedge clk); #1;
    chk("cnt0_done", done, 1);
    chk("cnt0_out_valid", out_valid, 0);
    finish_xfer(0, 1'b0);
    chk("cnt0_done_total", n_done - done_base, 1);

    // consumer stalled: only FIFO_DEPTH reads may be outstanding
    out_ready = 1'b0;
    start(0, 8);
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("stall_rd_en", n_rd - rd_base, DEPTH);
    chk("stall_valid", out_valid, 1);
    chk("stall_data", out_data, 100);
    out_ready = 1'b1;
    wait_done(1);
    finish_xfer(8, 1'b0);

    for (int k = 0; k < 6; k++) begin
      xfer($urandom_range(0, SIZE - 1), $urandom_range(0, SIZE), 2);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // asynchronous reset mid-issue
    out_ready = 1'b1;
    start(0, 8);
    for (int i = 0; i < 20 && (n_rd - rd_base) < 3; i++) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_no_done", n_done - done_base, 0);
    xfer(0, 2, 1);

    // stray read data while idle
    @(posedge clk); #1 inj = 1'b1;
    @(posedge clk); #1 inj = 1'b0;
    chk("stray_err", err, 1);
    exp_err = 1'b1;
    xfer(3, 5, 1);
    xfer($urandom_range(0, SIZE - 1), $urandom_range(1, SIZE), 2);
    do_reset();
    chk("err_cleared", err, 0);

    for (int k = 0; k < 3; k++) xfer($urandom_range(0, SIZE - 1), $urandom_range(0, SIZE), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
